spi_arbiter: RTL

Shares the single SPI master in the DSO front end between three requesters: the command decoder (AFE gain, trigger level, EEPROM read/write), the calibration coefficient fetcher, and the trigger-level refresh engine. The arbiter grants one requester at a time and latches that requester's 16-bit frame and slave select. It issues one `wrt_SPI` pulse to the SPI master, waits for `SPI_done`, and returns the read-back word. A watchdog aborts transactions that never complete. The block sits between the requesters and the SPI master.

---
 rtl/spi_arbiter_if.sv | 32 +++
 rtl/spi_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/spi_arbiter_if.sv
// Requester-side and SPI-master-side signal bundle for spi_arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface spi_arbiter_if;
    logic [2:0]  req;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic [15:0] req_data2;
    logic [2:0]  req_ss0;
    logic [2:0]  req_ss1;
    logic [2:0]  req_ss2;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic        timeout_err;
    logic        wrt_SPI;
    logic [15:0] SPI_data;
    logic [2:0]  ss;
    logic        SPI_done;
    logic [15:0] SPI_rdata;

    modport slave (
        input  req, req_data0, req_data1, req_data2, req_ss0, req_ss1, req_ss2,
        input  SPI_done, SPI_rdata,
        output gnt, done, rdata, timeout_err, wrt_SPI, SPI_data, ss
    );

    modport master (
        output req, req_data0, req_data1, req_data2, req_ss0, req_ss1, req_ss2,
        output SPI_done, SPI_rdata,
        input  gnt, done, rdata, timeout_err, wrt_SPI, SPI_data, ss
    );
endinterface

// File: rtl/spi_arbiter.sv
// Three-way arbiter in front of the single SPI master, with a transaction watchdog.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest); round-robin otherwise.
module spi_arbiter #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [2:0]       done_q, done_d;
    logic             timeout_err_q, timeout_err_d;
    logic [15:0]      spi_data_q, spi_data_d;
    logic [2:0]       ss_q, ss_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       win;
    logic             timeout_hit;

`ifdef SPI_ARB_FIXED_PRIO_EN
    always_comb begin
        win = 3'b000;
        if (bus.req[0])      win = 3'b001;
        else if (bus.req[1]) win = 3'b010;
        else if (bus.req[2]) win = 3'b100;
    end
`else
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] rot;
    logic [2:0] pick;

    // Rotate so that bit 0 is the pointed-to requester, pick the lowest set bit, rotate back.
    always_comb begin
        case (ptr_q)
            2'd1:    rot = {bus.req[0], bus.req[2], bus.req[1]};
            2'd2:    rot = {bus.req[1], bus.req[0], bus.req[2]};
            default: rot = bus.req;
        endcase
        pick = 3'b000;
        if (rot[0])      pick = 3'b001;
        else if (rot[1]) pick = 3'b010;
        else if (rot[2]) pick = 3'b100;
        case (ptr_q)
            2'd1:    win = {pick[1], pick[0], pick[2]};
            2'd2:    win = {pick[0], pick[2], pick[1]};
            default: win = pick;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == RELEASE) begin
            if (done_q[0])      ptr_d = 2'd1;
            else if (done_q[1]) ptr_d = 2'd2;
            else                ptr_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end
`endif

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= 3'b000;
            done_q        <= 3'b000;
            timeout_err_q <= 1'b0;
            spi_data_q    <= 16'h0000;
            ss_q          <= 3'b000;
            rdata_q       <= 16'h0000;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            spi_data_q    <= spi_data_d;
            ss_q          <= ss_d;
            rdata_q       <= rdata_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win != 3'b000) state_d = LAUNCH;
            LAUNCH:  state_d = BUSY;
            BUSY:    if (bus.SPI_done || timeout_hit) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SPI_done takes precedence over the watchdog when both land in the same cycle.
    always_comb begin
        gnt_d         = gnt_q;
        done_d        = 3'b000;
        timeout_err_d = 1'b0;
        spi_data_d    = spi_data_q;
        ss_d          = ss_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (win != 3'b000) begin
                    gnt_d      = win;
                    spi_data_d = ({16{win[0]}} & bus.req_data0) |
                                 ({16{win[1]}} & bus.req_data1) |
                                 ({16{win[2]}} & bus.req_data2);
                    ss_d       = ({3{win[0]}} & bus.req_ss0) |
                                 ({3{win[1]}} & bus.req_ss1) |
                                 ({3{win[2]}} & bus.req_ss2);
                    cnt_d      = '0;
                end
            end
            BUSY: begin
                if (bus.SPI_done) begin
                    rdata_d = bus.SPI_rdata;
                    done_d  = gnt_q;
                    gnt_d   = 3'b000;
                end else if (timeout_hit) begin
                    rdata_d       = 16'hFFFF;
                    done_d        = gnt_q;
                    timeout_err_d = 1'b1;
                    gnt_d         = 3'b000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.wrt_SPI     = (state_q == LAUNCH);
    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.SPI_data    = spi_data_q;
    assign bus.ss          = ss_q;
    assign bus.rdata       = rdata_q;
endmodule
